// File: rtl/nonogram_sequencer.sv
// rtl/nonogram_sequencer.sv - phase controller for the nonogram solver pipeline
// Steers FIFO writes, snapshots board metadata, runs the solve watchdog and fault path.
module nonogram_sequencer #(
  parameter int MAX_ROWS = 11,
  parameter int MAX_COLS = 11,
  parameter int MAX_NUM_OPTIONS = 84,
  parameter int LINE_W = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0] ERR_BYTE = 8'hEE,
  localparam int ROW_W = $clog2(MAX_ROWS + 1),
  localparam int COL_W = $clog2(MAX_COLS + 1),
  localparam int OPT_W = $clog2(MAX_NUM_OPTIONS + 1),
  localparam int OPTS_W = (MAX_ROWS + MAX_COLS) * OPT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              parsed,
  input  logic              parse_write,
  input  logic [LINE_W-1:0] parse_line,
  input  logic [ROW_W-1:0]  parse_m,
  input  logic [COL_W-1:0]  parse_n,
  input  logic [OPTS_W-1:0] parse_opts,
  input  logic              solve_write,
  input  logic [LINE_W-1:0] solve_line,
  input  logic              solved,
  input  logic              assembled,
  input  logic              tx_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [LINE_W-1:0] fifo_din,
  output logic              fifo_flush,
  output logic              solve_start,
  output logic              solver_abort,
  output logic              asm_start,
  output logic [ROW_W-1:0]  sol_m,
  output logic [COL_W-1:0]  sol_n,
  output logic [OPTS_W-1:0] sol_opts,
  output logic              err_valid,
  output logic [7:0]        err_byte,
  output logic [1:0]        state,
  output logic [7:0]        boards_solved,
  output logic              overflow,
  output logic              dropped
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    RECEIVE  = 2'd0,
    SOLVE    = 2'd1,
    TRANSMIT = 2'd2,
    FAULT    = 2'd3
  } phase_t;

  phase_t             state_q, state_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic [7:0]         boards_q, boards_d;
  logic [ROW_W-1:0]   m_d;
  logic [COL_W-1:0]   n_d;
  logic [OPTS_W-1:0]  opts_d;
  logic               start_d, asm_d, abort_d, flush_d;
  logic               ovf_d, drop_d;
  logic               wr_req, ovf_hit;

  // Write source follows the registered phase so the steering is valid in the write cycle.
  always_comb begin
    wr_req   = 1'b0;
    fifo_din = parse_line;
    if (state_q == RECEIVE) begin
      wr_req = parse_write;
    end else if (state_q == SOLVE) begin
      wr_req   = solve_write;
      fifo_din = solve_line;
    end
    fifo_wr_en = wr_req & ~fifo_full;
    ovf_hit    = wr_req & fifo_full;
  end

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    boards_d = boards_q;
    m_d      = sol_m;
    n_d      = sol_n;
    opts_d   = sol_opts;
    start_d  = 1'b0;
    asm_d    = 1'b0;
    abort_d  = 1'b0;
    flush_d  = 1'b0;
    ovf_d    = overflow | ovf_hit;
    drop_d   = dropped | ((state_q != RECEIVE) & (parse_write | parsed));
    case (state_q)
      RECEIVE: begin
        if (ovf_hit) begin
          state_d = FAULT;
        end else if (parsed) begin
          state_d = SOLVE;
          m_d     = parse_m;
          n_d     = parse_n;
          opts_d  = parse_opts;
          start_d = 1'b1;
          wd_d    = '0;
        end
      end
      SOLVE: begin
        wd_d = wd_q + TO_W'(1);
        // Overflow beats solved, and solved beats a coincident timeout.
        if (ovf_hit) begin
          state_d = FAULT;
          abort_d = 1'b1;
        end else if (solved) begin
          state_d  = TRANSMIT;
          asm_d    = 1'b1;
          boards_d = boards_q + 8'd1;
        end else if (wd_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = FAULT;
          abort_d = 1'b1;
        end
      end
      TRANSMIT: begin
        if (assembled) state_d = RECEIVE;
      end
      FAULT: begin
        if (tx_ready) begin
          state_d = RECEIVE;
          flush_d = 1'b1;
        end
      end
      default: state_d = RECEIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RECEIVE;
      wd_q         <= '0;
      boards_q     <= '0;
      sol_m        <= '0;
      sol_n        <= '0;
      sol_opts     <= '0;
      solve_start  <= 1'b0;
      asm_start    <= 1'b0;
      solver_abort <= 1'b0;
      fifo_flush   <= 1'b0;
      err_valid    <= 1'b0;
      overflow     <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      boards_q     <= boards_d;
      sol_m        <= m_d;
      sol_n        <= n_d;
      sol_opts     <= opts_d;
      solve_start  <= start_d;
      asm_start    <= asm_d;
      solver_abort <= abort_d;
      fifo_flush   <= flush_d;
      err_valid    <= (state_d == FAULT);
      overflow     <= ovf_d;
      dropped      <= drop_d;
    end
  end

  assign state         = state_q;
  assign boards_solved = boards_q;
  assign err_byte      = ERR_BYTE;

endmodule

// File: tb/tb_nonogram_sequencer.sv
// tb/tb_nonogram_sequencer.sv - scoreboard bench for nonogram_sequencer
// Driver feeds a cycle-stamped reference model; a negedge monitor pops and compares.
module tb_nonogram_sequencer;

  localparam int T      = 100;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int OPTS_W = 22 * 7;

  logic clk = 1'b0;
  logic rst_n;
  logic parsed, parse_write, solve_write, solved, assembled, tx_ready, fifo_full;
  logic [15:0] parse_line, solve_line;
  logic [ROW_W-1:0] parse_m;
  logic [COL_W-1:0] parse_n;
  logic [OPTS_W-1:0] parse_opts;
  logic fifo_wr_en, fifo_flush, solve_start, solver_abort, asm_start, err_valid;
  logic [15:0] fifo_din;
  logic [ROW_W-1:0] sol_m;
  logic [COL_W-1:0] sol_n;
  logic [OPTS_W-1:0] sol_opts;
  logic [7:0] err_byte, boards_solved;
  logic [1:0] state;
  logic overflow, dropped;

  nonogram_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .parsed(parsed), .parse_write(parse_write),
    .parse_line(parse_line), .parse_m(parse_m), .parse_n(parse_n), .parse_opts(parse_opts),
    .solve_write(solve_write), .solve_line(solve_line), .solved(solved),
    .assembled(assembled), .tx_ready(tx_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_flush(fifo_flush),
    .solve_start(solve_start), .solver_abort(solver_abort), .asm_start(asm_start),
    .sol_m(sol_m), .sol_n(sol_n), .sol_opts(sol_opts), .err_valid(err_valid),
    .err_byte(err_byte), .state(state), .boards_solved(boards_solved),
    .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pw; logic [15:0] pl; bit parsed; logic [ROW_W-1:0] m; logic [COL_W-1:0] n;
    logic [OPTS_W-1:0] opts; bit sw; logic [15:0] sl; bit solved, assembled, txr, full;
  } in_t;
  typedef struct { int cyc; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic [3:0] mask; } ev_t;   // {start, asm, abort, flush}
  typedef struct { logic [28:0] v; logic [OPTS_W-1:0] o; } st_t;

  wr_t wq[$];
  ev_t eq[$];
  st_t sq[$];

  int checks = 0, failures = 0;
  int cyc = 0, cur_cyc = 0;
  bit mon_en = 0;

  int m_phase, m_entry, m_boards;
  bit m_ovf, m_drp;
  logic [ROW_W-1:0] m_m;
  logic [COL_W-1:0] m_n;
  logic [OPTS_W-1:0] m_opts;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cur_cyc, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t r;
    r.pw = 0; r.pl = '0; r.parsed = 0; r.m = '0; r.n = '0; r.opts = '0;
    r.sw = 0; r.sl = '0; r.solved = 0; r.assembled = 0; r.txr = 0; r.full = 0;
    return r;
  endfunction

  function automatic logic [OPTS_W-1:0] ropts();
    logic [OPTS_W-1:0] r;
    for (int k = 0; k < OPTS_W; k++) r[k] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_entry = 0; m_boards = 0; m_ovf = 0; m_drp = 0;
    m_m = '0; m_n = '0; m_opts = '0;
  endtask

  task automatic drive(input in_t i);
    parse_write = i.pw; parse_line = i.pl; parsed = i.parsed; parse_m = i.m;
    parse_n = i.n; parse_opts = i.opts; solve_write = i.sw; solve_line = i.sl;
    solved = i.solved; assembled = i.assembled; tx_ready = i.txr; fifo_full = i.full;
  endtask

  // One clock of stimulus; the model applies the phase rules for this cycle.
  task automatic step(input in_t i);
    st_t s;
    bit req, ovf_now;
    logic [3:0] mask;
    int nph;
    @(posedge clk);
    #1;
    drive(i);
    mon_en = 1;
    cur_cyc = cyc;
    s.v = {2'(m_phase), m_ovf, m_drp, 8'(m_boards), (m_phase == 3), 8'hEE, m_m, m_n};
    s.o = m_opts;
    sq.push_back(s);
    req = (m_phase == 0) ? i.pw : (m_phase == 1) ? i.sw : 1'b0;
    if (req && !i.full) wq.push_back('{cyc, (m_phase == 1) ? i.sl : i.pl});
    ovf_now = req && i.full;
    if (ovf_now) m_ovf = 1;
    if (m_phase != 0 && (i.pw || i.parsed)) m_drp = 1;
    mask = 4'b0;
    nph = m_phase;
    case (m_phase)
      0: if (ovf_now) nph = 3;
         else if (i.parsed) begin
           nph = 1; mask = 4'b1000; m_entry = cyc + 1;
           m_m = i.m; m_n = i.n; m_opts = i.opts;
         end
      1: if (ovf_now) begin nph = 3; mask = 4'b0010; end
         else if (i.solved) begin nph = 2; mask = 4'b0100; m_boards = (m_boards + 1) % 256; end
         else if (cyc + 1 - m_entry == T) begin nph = 3; mask = 4'b0010; end
      2: if (i.assembled) nph = 0;
      default: if (i.txr) begin nph = 0; mask = 4'b0001; end
    endcase
    if (mask != 0) eq.push_back('{cyc + 1, mask});
    m_phase = nph;
    cyc++;
  endtask

  task automatic check_reset_values();
    chk("rst_outputs", {state, overflow, dropped, boards_solved, err_valid, fifo_wr_en,
        solve_start, asm_start, solver_abort, fifo_flush, sol_m, sol_n}, '0);
    chk("rst_opts", sol_opts, '0);
    chk("rst_err_byte", err_byte, 8'hEE);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en = 0;
    drive(idle());
    rst_n = 0;
    #1;
    check_reset_values();
    wq.delete(); eq.delete(); sq.delete();
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      st_t s;
      wr_t w;
      ev_t e;
      logic [3:0] pulses;
      if (sq.size() == 0) chk("status_underflow", 1'b1, 1'b0);
      else begin
        s = sq.pop_front();
        chk("status", {state, overflow, dropped, boards_solved, err_valid, err_byte, sol_m, sol_n}, s.v);
        chk("sol_opts", sol_opts, s.o);
      end
      if (fifo_wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", fifo_wr_en, 1'b0);
        else begin
          w = wq.pop_front();
          chk("fifo_write", {cur_cyc, fifo_din}, {w.cyc, w.data});
        end
      end
      pulses = {solve_start, asm_start, solver_abort, fifo_flush};
      if (pulses != 0) begin
        if (eq.size() == 0) chk("pulse_unexpected", pulses, 4'b0);
        else begin
          e = eq.pop_front();
          chk("pulse", {cur_cyc, pulses}, {e.cyc, e.mask});
        end
      end
    end
  end

  initial begin
    in_t i;
    int b0;
    drive(idle());
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    #1;
    rst_n = 1;

    // nominal 5x5 board
    for (int k = 0; k < 10; k++) begin
      i = idle(); i.pw = 1; i.pl = 16'($urandom); step(i);
    end
    i = idle(); i.parsed = 1; i.m = 5; i.n = 5; i.opts = ropts(); step(i);
    repeat (3) step(idle());
    for (int k = 0; k < 2; k++) begin
      i = idle(); i.sw = 1; i.sl = 16'($urandom); step(i);
    end
    i = idle(); i.solved = 1; step(i);
    repeat (2) step(idle());
    i = idle(); i.assembled = 1; step(i);
    step(idle());

    // timeout, then err_valid held through 20 cycles of tx_ready=0
    i = idle(); i.parsed = 1; i.m = 11; i.n = 11; i.opts = ropts(); step(i);
    repeat (T + 20) step(idle());
    i = idle(); i.txr = 1; step(i);
    step(idle());

    // overflow from RECEIVE
    i = idle(); i.pw = 1; i.pl = 16'hBEEF; i.full = 1; step(i);
    repeat (3) step(idle());
    i = idle(); i.txr = 1; step(i);
    repeat (2) step(idle());

    // solved on the timeout cycle, then parse_write during TRANSMIT
    i = idle(); i.parsed = 1; i.m = 3; i.n = 7; i.opts = ropts(); step(i);
    repeat (T - 1) step(idle());
    i = idle(); i.solved = 1; step(i);
    i = idle(); i.pw = 1; i.pl = 16'h1234; step(i);
    i = idle(); i.assembled = 1; step(i);

    // 256 boards wrap the counter
    b0 = m_boards;
    for (int k = 0; k < 256; k++) begin
      i = idle(); i.parsed = 1; i.m = 4'($urandom_range(1, 11)); i.n = 4'($urandom_range(1, 11));
      i.opts = ropts(); step(i);
      i = idle(); i.solved = 1; step(i);
      i = idle(); i.assembled = 1; step(i);
    end
    step(idle());
    chk("boards_wrap", boards_solved, 8'(b0));

    // reset mid-SOLVE
    i = idle(); i.parsed = 1; i.m = 2; i.n = 2; i.opts = ropts(); step(i);
    repeat (5) step(idle());
    do_reset();
    repeat (5) step(idle());

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      i.pw = ($urandom_range(0, 99) < 30); i.pl = 16'($urandom);
      i.parsed = ($urandom_range(0, 99) < 8);
      i.m = 4'($urandom_range(0, 11)); i.n = 4'($urandom_range(0, 11)); i.opts = ropts();
      i.sw = ($urandom_range(0, 99) < 30); i.sl = 16'($urandom);
      i.solved = ($urandom_range(0, 99) < 2);
      i.assembled = ($urandom_range(0, 99) < 20);
      i.txr = ($urandom_range(0, 99) < 25);
      i.full = ($urandom_range(0, 99) < 3);
      step(i);
    end
    step(idle());
    @(negedge clk);
    #1;
    chk("wq_drained", wq.size(), 0);
    chk("eq_drained", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
